seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver_if.sv | 34 +++
 rtl/seg7_scan_driver.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the bus-side write/control signals and the registered display
// outputs of the 4-digit 7-segment scan driver.
//   we        : write strobe for data_in
//   data_in   : 16-bit hex value, nibble k shown on digit k (digit 0 rightmost)
//   dp_in     : per-digit decimal point enable (live)
//   blank_lz  : leading-zero suppression enable (live)
//   seg       : cathodes, active-low, seg[0]=a .. seg[6]=g
//   an        : anodes, active-low one-hot
//   dp        : decimal point, active-low
//   scan_wrap : one-cycle pulse after the digit index wraps 3->0
// master = bus/controller side, slave = scan driver.
// ---------------------------------------------------------------------------
interface seg7_scan_driver_if;
    logic        we;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        scan_wrap;

    modport master (
        output we, data_in, dp_in, blank_lz,
        input  seg, an, dp, scan_wrap
    );

    modport slave (
        input  we, data_in, dp_in, blank_lz,
        output seg, an, dp, scan_wrap
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Latches a 16-bit value from the bus side and time-multiplexes it onto a
// 4-digit common-anode 7-segment display. Each digit owns a slot of
// REFRESH_DIV clocks; the first BLANK_CYCLES clocks of every slot keep all
// anodes off so the previous digit's pattern never ghosts onto the next one.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : seg7_scan_driver_if.slave (we, data_in, dp_in, blank_lz in;
//           seg, an, dp, scan_wrap out, all outputs registered)
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    seg7_scan_driver_if.slave        bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    logic [15:0]      data_q;
    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic             slot_end;

    logic [3:0]       nibble_p0;
    logic             blank_p0;
    logic [6:0]       seg_p0;
    logic [3:0]       an_p0;
    logic             dp_p0;

    logic [6:0]       seg_p1;
    logic [3:0]       an_p1;
    logic             dp_p1;
    logic             wrap_p1;

    // Hex digit to active-low gfedcba pattern.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every more significant nibble
    // are zero. Digit 0 is always shown so a zero value still reads "0".
    function automatic logic is_leading_zero(input logic [15:0] d,
                                             input logic [1:0]  i);
        logic z;
        case (i)
            2'd1:    z = (d[15:4]  == 12'h000);
            2'd2:    z = (d[15:8]  == 8'h00);
            2'd3:    z = (d[15:12] == 4'h0);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

    // ---- stage p0: data latch, prescaler, digit index, output decode ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 16'h0000;
        end else if (bus.we) begin
            data_q <= bus.data_in;
        end
    end

    assign slot_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else if (slot_end) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Decode uses one snapshot of data_q, so a write landing on a slot
    // boundary shows up whole on the next update rather than half-applied.
    always_comb begin
        nibble_p0 = data_q[{idx, 2'b00} +: 4];
        blank_p0  = (div_cnt < BLANK_END) ||
                    (bus.blank_lz && is_leading_zero(data_q, idx));
        seg_p0    = SEG_OFF;
        an_p0     = AN_OFF;
        dp_p0     = 1'b1;
        if (!blank_p0) begin
            seg_p0 = hex7(nibble_p0);
            an_p0  = ~(4'b0001 << idx);
            dp_p0  = ~bus.dp_in[idx];
        end
    end

    // ---- stage p1: registered display outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p1  <= SEG_OFF;
            an_p1   <= AN_OFF;
            dp_p1   <= 1'b1;
            wrap_p1 <= 1'b0;
        end else begin
            seg_p1  <= seg_p0;
            an_p1   <= an_p0;
            dp_p1   <= dp_p0;
            wrap_p1 <= slot_end && (idx == 2'd3);
        end
    end

    assign bus.seg       = seg_p1;
    assign bus.an        = an_p1;
    assign bus.dp        = dp_p1;
    assign bus.scan_wrap = wrap_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2.
// Expected display states are hand-computed and queued with the clock tick
// at which they must be visible; a monitor samples the outputs on every
// falling edge and compares against the head of the queue.
// Edge k after reset release (tick base+k) shows slot ((k-1)/8)%4 at phase
// (k-1)%8; phases 0..1 are blanked.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int RD = 8;
    localparam int BC = 2;

    logic clk;
    logic rst_n;

    seg7_scan_driver_if bus_if();

    seg7_scan_driver #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        int         at;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       wrap;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   tick  = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   base  = 3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    // Monitor: compare every expectation due at this tick.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= tick) begin
            cur = sb.pop_front();
            n_vec++;
            if (cur.at < tick) begin
                n_bad++;
                $display("FAIL %s: not sampled at tick %0d (now %0d)", cur.name, cur.at, tick);
            end else if (bus_if.an !== cur.an || bus_if.seg !== cur.seg ||
                         bus_if.dp !== cur.dp || bus_if.scan_wrap !== cur.wrap) begin
                n_bad++;
                $display("FAIL %s @tick %0d: got an=%b seg=%h dp=%b wrap=%b, want an=%b seg=%h dp=%b wrap=%b",
                         cur.name, tick, bus_if.an, bus_if.seg, bus_if.dp, bus_if.scan_wrap,
                         cur.an, cur.seg, cur.dp, cur.wrap);
            end
        end
    end

    task automatic chk(input int k, input logic [3:0] a, input logic [6:0] s,
                       input logic d, input logic w, input string nm);
        exp_t e;
        e.at = base + k; e.an = a; e.seg = s; e.dp = d; e.wrap = w; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic chk_blank(input int k, input logic w, input string nm);
        chk(k, 4'b1111, 7'h7F, 1'b1, w, nm);
    endtask

    task automatic wait_tick(input int t);
        while (tick < t) @(negedge clk);
    endtask

    // Drive so that we is sampled on edge k; display reflects it from k+1.
    task automatic write_at(input int k, input logic [15:0] v,
                            input logic [3:0] dpv, input logic lz);
        wait_tick(base + k - 1);
        bus_if.we       = 1'b1;
        bus_if.data_in  = v;
        bus_if.dp_in    = dpv;
        bus_if.blank_lz = lz;
        @(negedge clk);
        bus_if.we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tick=%0d", tick);
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b0;
        bus_if.we       = 1'b0;
        bus_if.data_in  = 16'h0000;
        bus_if.dp_in    = 4'b0000;
        bus_if.blank_lz = 1'b0;

        // Expectations, in tick order.
        chk_blank(-1, 1'b0, "reset_state");
        // Free-running scan with data_q = 0
        chk_blank(1, 1'b0, "rel_blank_p0");
        chk_blank(2, 1'b0, "rel_blank_p1");
        chk(3,  4'b1110, 7'h40, 1'b1, 1'b0, "scan_d0_first");
        chk(8,  4'b1110, 7'h40, 1'b1, 1'b0, "scan_d0_last");
        chk_blank(9, 1'b0, "scan_d1_blank");
        chk(11, 4'b1101, 7'h40, 1'b1, 1'b0, "scan_d1");
        chk(19, 4'b1011, 7'h40, 1'b1, 1'b0, "scan_d2");
        chk(27, 4'b0111, 7'h40, 1'b1, 1'b0, "scan_d3");
        chk(31, 4'b0111, 7'h40, 1'b1, 1'b0, "wrap_low_before");
        chk(32, 4'b0111, 7'h40, 1'b1, 1'b1, "wrap_pulse_1");
        chk_blank(33, 1'b0, "wrap_low_after");
        chk(64, 4'b0111, 7'h40, 1'b1, 1'b1, "wrap_pulse_2");
        // 0x1A3F, no suppression
        chk(67, 4'b1110, 7'h0E, 1'b1, 1'b0, "h1A3F_d0");
        chk(75, 4'b1101, 7'h30, 1'b1, 1'b0, "h1A3F_d1");
        chk(83, 4'b1011, 7'h08, 1'b1, 1'b0, "h1A3F_d2");
        chk(91, 4'b0111, 7'h79, 1'b1, 1'b0, "h1A3F_d3");
        chk(96, 4'b0111, 7'h79, 1'b1, 1'b1, "h1A3F_wrap");
        // 0x0005 with leading-zero suppression
        chk(99, 4'b1110, 7'h12, 1'b1, 1'b0, "lz5_d0");
        chk_blank(107, 1'b0, "lz5_d1_mid");
        chk_blank(112, 1'b0, "lz5_d1_end");
        chk_blank(115, 1'b0, "lz5_d2");
        chk_blank(123, 1'b0, "lz5_d3");
        chk_blank(128, 1'b1, "lz5_wrap");
        // 0x0000 with suppression: lone "0"
        chk(131, 4'b1110, 7'h40, 1'b1, 1'b0, "lz0_d0");
        chk_blank(139, 1'b0, "lz0_d1");
        chk_blank(147, 1'b0, "lz0_d2");
        chk_blank(155, 1'b0, "lz0_d3");
        // 0x8888, decimal point on digit 2
        chk(163, 4'b1110, 7'h00, 1'b1, 1'b0, "dp_d0");
        chk(171, 4'b1101, 7'h00, 1'b1, 1'b0, "dp_d1");
        chk_blank(177, 1'b0, "dp_d2_blank0");
        chk_blank(178, 1'b0, "dp_d2_blank1");
        chk(179, 4'b1011, 7'h00, 1'b0, 1'b0, "dp_d2_on");
        chk(184, 4'b1011, 7'h00, 1'b0, 1'b0, "dp_d2_end");
        chk(187, 4'b0111, 7'h00, 1'b1, 1'b0, "dp_d3");
        chk(192, 4'b0111, 7'h00, 1'b1, 1'b1, "dp_wrap");
        // Remaining hex glyphs
        chk(195, 4'b1110, 7'h10, 1'b1, 1'b0, "hex_9");
        chk(203, 4'b1101, 7'h02, 1'b1, 1'b0, "hex_6");
        chk(211, 4'b1011, 7'h19, 1'b1, 1'b0, "hex_4");
        chk(219, 4'b0111, 7'h24, 1'b1, 1'b0, "hex_2");
        chk(227, 4'b1110, 7'h06, 1'b1, 1'b0, "hex_E");
        chk(235, 4'b1101, 7'h21, 1'b1, 1'b0, "hex_d");
        chk(243, 4'b1011, 7'h46, 1'b1, 1'b0, "hex_C");
        chk(251, 4'b0111, 7'h03, 1'b1, 1'b0, "hex_b");
        chk(256, 4'b0111, 7'h03, 1'b1, 1'b1, "hex_wrap");
        // Write latency mid digit-0 slot, then async reset
        chk(259, 4'b1110, 7'h06, 1'b1, 1'b0, "lat_old_value");
        chk(260, 4'b1110, 7'h78, 1'b1, 1'b0, "lat_new_value");
        chk(261, 4'b1110, 7'h78, 1'b1, 1'b0, "lat_hold");
        chk_blank(262, 1'b0, "async_rst_same_cycle");
        chk_blank(264, 1'b0, "async_rst_held");
        chk_blank(265, 1'b0, "rerel_blank_p0");
        chk_blank(266, 1'b0, "rerel_blank_p1");
        chk(267, 4'b1110, 7'h40, 1'b1, 1'b0, "rerel_d0_zero");
        chk(272, 4'b1110, 7'h40, 1'b1, 1'b0, "rerel_d0_end");
        chk(275, 4'b1101, 7'h40, 1'b1, 1'b0, "rerel_d1");

        // Stimulus
        wait_tick(base);
        rst_n = 1'b1;

        write_at(65,  16'h1A3F, 4'b0000, 1'b0);
        write_at(97,  16'h0005, 4'b0000, 1'b1);
        write_at(129, 16'h0000, 4'b0000, 1'b1);
        write_at(161, 16'h8888, 4'b0100, 1'b0);
        write_at(193, 16'h2469, 4'b0000, 1'b0);
        write_at(225, 16'hBCDE, 4'b0000, 1'b0);
        write_at(259, 16'h0007, 4'b0000, 1'b0);

        wait_tick(base + 261);
        @(posedge clk);
        #1 rst_n = 1'b0;
        wait_tick(base + 264);
        rst_n = 1'b1;

        wait_tick(base + 280);
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: expectation never checked (due tick %0d)", cur.name, cur.at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
